// File: rtl/operand_regfile.sv
// operand_regfile: register file, operand capture with write forwarding, and flag register feeding the 8-bit ALU
//   clk, reset_n (sync, active low); issue_vld/stall/rd_addr_a/rd_addr_b -> op_a/op_b/op_vld
//   wr_en/wr_addr/wr_data writeback; flag_we/clr_c/sc_in/zero_in/pari_in -> carry_o/zero_flag/pari_flag
//   OPERAND_R0_ZERO_EN: register 0 reads as zero, ignores writes and is never forwarded
module operand_regfile #(
    parameter int DW = 8,
    parameter int NREG = 8,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue_vld,
    input  logic          stall,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          flag_we,
    input  logic          clr_c,
    input  logic          sc_in,
    input  logic          zero_in,
    input  logic          pari_in,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_vld,
    output logic          carry_o,
    output logic          zero_flag,
    output logic          pari_flag
);
`ifdef OPERAND_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    logic [DW-1:0] regs [NREG];
    logic          wr_ok;
    logic [DW-1:0] fwd_a, fwd_b;
    always_comb begin
        wr_ok = wr_en && !(R0Z && wr_addr == '0);
        // a hard-wired zero register is checked first so it beats forwarding
        fwd_a = (R0Z && rd_addr_a == '0) ? '0 : (wr_ok && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
        fwd_b = (R0Z && rd_addr_b == '0) ? '0 : (wr_ok && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_vld <= 1'b0;
        end else if (!stall) begin
            op_vld <= issue_vld;
            if (issue_vld) begin
                op_a <= fwd_a;
                op_b <= fwd_b;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry_o   <= 1'b0;
            zero_flag <= 1'b0;
            pari_flag <= 1'b0;
        end else begin
            carry_o <= clr_c ? 1'b0 : flag_we ? sc_in : carry_o;
            if (flag_we) begin
                zero_flag <= zero_in;
                pari_flag <= pari_in;
            end
        end
    end
endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: scoreboard bench for operand_regfile
module tb_operand_regfile;
`ifdef OPERAND_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue_vld = 1'b0, stall = 1'b0, wr_en = 1'b0;
    logic [2:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       flag_we = 1'b0, clr_c = 1'b0, sc_in = 1'b0, zero_in = 1'b0, pari_in = 1'b0;
    logic [7:0] op_a, op_b;
    logic       op_vld, carry_o, zero_flag, pari_flag;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0]  m_regs [8];
    logic [15:0] exp_q [$];
    logic [7:0]  cur_a = '0, cur_b = '0;
    logic        exp_vld = 1'b0, exp_c = 1'b0, exp_z = 1'b0, exp_p = 1'b0;

    operand_regfile dut (
        .clk(clk), .reset_n(reset_n), .issue_vld(issue_vld), .stall(stall),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .flag_we(flag_we), .clr_c(clr_c), .sc_in(sc_in),
        .zero_in(zero_in), .pari_in(pari_in), .op_a(op_a), .op_b(op_b), .op_vld(op_vld),
        .carry_o(carry_o), .zero_flag(zero_flag), .pari_flag(pari_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mfwd(input logic [2:0] x);
        if (R0Z && x == 3'd0) return 8'h00;
        if (wr_en && wr_addr == x) return wr_data;
        return m_regs[x];
    endfunction

    task automatic step();
        logic [15:0] e;
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            exp_q.delete();
            cur_a = '0;
            cur_b = '0;
            exp_vld = 1'b0;
            {exp_c, exp_z, exp_p} = 3'b000;
        end else begin
            if (!stall) begin
                exp_vld = issue_vld;
                if (issue_vld) exp_q.push_back({mfwd(rd_addr_a), mfwd(rd_addr_b)});
            end
            if (wr_en && !(R0Z && wr_addr == 3'd0)) m_regs[wr_addr] = wr_data;
            exp_c = clr_c ? 1'b0 : flag_we ? sc_in : exp_c;
            if (flag_we) {exp_z, exp_p} = {zero_in, pari_in};
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {cur_a, cur_b} = e;
        end
        check("op_a", op_a, cur_a);
        check("op_b", op_b, cur_b);
        check("op_vld", {7'd0, op_vld}, {7'd0, exp_vld});
        check("carry", {7'd0, carry_o}, {7'd0, exp_c});
        check("zero", {7'd0, zero_flag}, {7'd0, exp_z});
        check("pari", {7'd0, pari_flag}, {7'd0, exp_p});
    endtask

    task automatic wr(input logic we, input logic [2:0] a, input logic [7:0] d);
        wr_en = we;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic rd(input logic iv, input logic [2:0] a, input logic [2:0] b);
        issue_vld = iv;
        rd_addr_a = a;
        rd_addr_b = b;
    endtask

    initial begin
        step();
        step();
        reset_n = 1'b1;
        wr(1, 3, 8'hA5);
        step();
        reset_n = 1'b0;
        wr(1, 3, 8'h5A);
        flag_we = 1'b1;
        sc_in = 1'b1;
        pari_in = 1'b1;
        rd(1, 3, 3);
        step();
        check("rst_op_a", op_a, 8'h00);
        check("rst_vld", {7'd0, op_vld}, 8'h00);
        check("rst_carry", {7'd0, carry_o}, 8'h00);
        reset_n = 1'b1;
        flag_we = 1'b0;
        wr(0, 0, 0);
        rd(1, 3, 3);
        step();
        check("rst_r3", op_a, 8'h00);
        wr(1, 5, 8'h11);
        rd(0, 0, 0);
        step();
        wr(1, 2, 8'h3C);
        rd(1, 2, 5);
        step();
        check("fwd_a", op_a, 8'h3C);
        check("fwd_b", op_b, 8'h11);
        check("fwd_vld", {7'd0, op_vld}, 8'h01);
        wr(0, 0, 0);
        rd(1, 2, 0);
        step();
        check("stored_r2", op_a, 8'h3C);
        wr(1, 1, 8'h10);
        rd(0, 0, 0);
        step();
        wr(1, 6, 8'h77);
        rd(1, 1, 1);
        step();
        check("pre_stall", op_a, 8'h10);
        stall = 1'b1;
        rd(1, 6, 6);
        wr(0, 0, 0);
        flag_we = 1'b1;
        {sc_in, zero_in, pari_in} = 3'b011;
        step();
        flag_we = 1'b0;
        wr(1, 7, 8'h99);
        step();
        wr(0, 0, 0);
        step();
        check("stall_a", op_a, 8'h10);
        check("stall_vld", {7'd0, op_vld}, 8'h01);
        stall = 1'b0;
        step();
        check("unstall_a", op_a, 8'h77);
        rd(1, 7, 6);
        step();
        check("stall_wr", op_a, 8'h99);
        rd(0, 0, 0);
        flag_we = 1'b1;
        {sc_in, zero_in, pari_in} = 3'b101;
        step();
        check("flag_c", {7'd0, carry_o}, 8'h01);
        check("flag_z", {7'd0, zero_flag}, 8'h00);
        check("flag_p", {7'd0, pari_flag}, 8'h01);
        clr_c = 1'b1;
        {sc_in, zero_in, pari_in} = 3'b110;
        step();
        check("clr_c", {7'd0, carry_o}, 8'h00);
        check("clr_z", {7'd0, zero_flag}, 8'h01);
        clr_c = 1'b0;
        flag_we = 1'b0;
        sc_in = 1'b1;
        step();
        wr(1, 4, 8'hFF);
        step();
        wr(0, 0, 0);
        rd(1, 4, 4);
        step();
        check("same_a", op_a, 8'hFF);
        check("same_b", op_b, 8'hFF);
        wr(1, 4, 8'hC3);
        step();
        check("same_fwd", op_b, 8'hC3);
        wr(1, 0, 8'h55);
        rd(1, 0, 4);
        step();
        check("r0_fwd", op_a, R0Z ? 8'h00 : 8'h55);
        wr(0, 0, 0);
        step();
        check("r0_stored", op_a, R0Z ? 8'h00 : 8'h55);
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            rd($urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            wr($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            flag_we = $urandom_range(0, 1);
            clr_c = ($urandom_range(0, 3) == 0);
            {sc_in, zero_in, pari_in} = 3'($urandom_range(0, 7));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
